// File: rtl/t06_scan_pkg.sv
// Shared types and default colours for the grid raster scanner.
package t06_scan_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SCAN  = ST_SCAN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_t;

  typedef enum logic [1:0] {BG, APPLE, BODY, HEAD} pixel_class_t;

  localparam logic [15:0] DEF_COLOR_BG    = 16'h0000;
  localparam logic [15:0] DEF_COLOR_BODY  = 16'h07E0;
  localparam logic [15:0] DEF_COLOR_HEAD  = 16'hFFE0;
  localparam logic [15:0] DEF_COLOR_APPLE = 16'hF800;
  localparam logic [15:0] DEF_COLOR_DEAD  = 16'hF81F;

endpackage

// File: rtl/t06_coord_counter.sv
// Raster x/y counter; parks on the last cell until cleared.
module t06_coord_counter #(
  parameter int unsigned GRID_W = 16,
  parameter int unsigned GRID_H = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic       last
);

  assign last = (x == 4'(GRID_W - 1)) && (y == 4'(GRID_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (en && !last) begin
      if (x == 4'(GRID_W - 1)) begin
        x <= '0;
        y <= y + 4'd1;
      end else begin
        x <= x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/t06_grid_scanner.sv
// Walks the play grid, classifies each cell from the wrapper hits and
// streams one colour per cell through a single-entry valid/ready register.
module t06_grid_scanner
  import t06_scan_pkg::*;
#(
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter logic [15:0] COLOR_BG    = DEF_COLOR_BG,
  parameter logic [15:0] COLOR_BODY  = DEF_COLOR_BODY,
  parameter logic [15:0] COLOR_HEAD  = DEF_COLOR_HEAD,
  parameter logic [15:0] COLOR_APPLE = DEF_COLOR_APPLE,
  parameter logic [15:0] COLOR_DEAD  = DEF_COLOR_DEAD
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        game_over,
  input  logic        body,
  input  logic        head,
  input  logic        apple,
  output logic [3:0]  x,
  output logic [3:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_x,
  output logic [3:0]  out_y,
  output logic [15:0] out_color,
  output logic        busy,
  output logic        frame_done
);

  state_t       state;
  pixel_class_t cls;
  logic [15:0]  color;
  logic         adv;
  logic         xfer;
  logic         last;
  logic         clear;

  assign xfer  = out_valid & out_ready;
  assign adv   = (state == SCAN) & (~out_valid | out_ready);
  assign clear = (state == IDLE) & start;

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  // The counter only steps on adv, so a stalled pixel keeps the wrapper query stable.
  t06_coord_counter #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_coord (
    .clk   (system_clk),
    .rst   (reset),
    .clear (clear),
    .en    (adv),
    .x     (x),
    .y     (y),
    .last  (last)
  );

  always_comb begin
    cls = BG;
    if (head)       cls = HEAD;
    else if (body)  cls = BODY;
    else if (apple) cls = APPLE;
  end

  always_comb begin
    color = COLOR_BG;
    case (cls)
      HEAD:    color = game_over ? COLOR_DEAD : COLOR_HEAD;
      BODY:    color = game_over ? COLOR_DEAD : COLOR_BODY;
      APPLE:   color = COLOR_APPLE;
      default: color = COLOR_BG;
    endcase
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= SCAN;
        SCAN:    if (adv && last) state <= DRAIN;
        DRAIN:   if (xfer) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_x     <= x;
      out_y     <= y;
      out_color <= color;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/t06_grid_scanner.md
Name: t06_grid_scanner

Overview:
- Raster scanner that sits directly downstream of the snake body/collision wrapper.
- Walks every cell of the 16x16 play grid, drives the x/y query coordinates into the wrapper, and samples its combinational body/head hits plus the apple hit.
- Emits one colour per cell through a valid/ready stream to the display driver, with a one-entry output register, backpressure stall and a frame-done pulse.

Parameters:
- GRID_W, 16, cells per row (x wraps at GRID_W-1; max 16).
- GRID_H, 16, rows per frame (max 16).
- COLOR_BG, 16'h0000, background colour (RGB565).
- COLOR_BODY, 16'h07E0, body segment colour.
- COLOR_HEAD, 16'hFFE0, head colour.
- COLOR_APPLE, 16'hF800, apple colour.
- COLOR_DEAD, 16'hF81F, head/body colour while game_over=1.

Ports:
- system_clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  frame request pulse; sampled only in IDLE
- game_over  in  1  recolour snake cells with COLOR_DEAD
- body  in  1  wrapper body hit for current x,y; combinational, same cycle
- head  in  1  wrapper head hit for current x,y; combinational, same cycle
- apple  in  1  apple hit for current x,y; combinational, same cycle
- x  out  4  query column driven to wrapper
- y  out  4  query row driven to wrapper
- out_valid  out  1  pixel stream valid
- out_ready  in  1  display driver ready
- out_x  out  4  column of the presented pixel
- out_y  out  4  row of the presented pixel
- out_color  out  16  colour of the presented pixel
- busy  out  1  high while not in IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset, asynchronous and immediate: state=IDLE; x, y, out_x, out_y, out_color = 0; out_valid, busy, frame_done = 0. Reset mid-frame abandons the frame, and no frame_done is issued.
- Definitions:
  - xfer = out_valid & out_ready.
  - adv = state==SCAN & (!out_valid | out_ready).
- IDLE:
  - start=1 -> SCAN, x=0, y=0, busy=1.
  - start=0 -> stay.
- SCAN, on adv:
  - Load out_x/out_y = x/y, out_color = class(head, body, apple, game_over), out_valid = 1.
  - Advance x. At x==GRID_W-1, x=0 and y++.
  - At (GRID_W-1, GRID_H-1) -> DRAIN; x/y hold.
- SCAN, without adv (stall): x/y and the output register hold, so the wrapper query stays stable.
- xfer without a new load clears out_valid.
- DRAIN: on xfer -> DONE, out_valid=0.
- DONE: frame_done=1 for exactly one cycle -> IDLE, busy=0.
- start while busy is ignored. start in the same cycle DONE exits is ignored; the next start is honoured from IDLE.
- Colour priority:
  - head -> COLOR_HEAD, or COLOR_DEAD if game_over.
  - else body -> COLOR_BODY, or COLOR_DEAD if game_over.
  - else apple -> COLOR_APPLE.
  - else COLOR_BG.
- Inputs are sampled on the adv edge with the x/y current that cycle. A lookup result is never paired with a different coordinate.
- Timing with out_ready held at 1 (start high at edge 0):
  - First out_valid after edge 1 (pixel 0,0).
  - Pixel n is presented after edge n+1.
  - Last pixel (15,15) is presented after edge 256 and accepted at edge 257.
  - frame_done is high after edge 257.
  - IDLE after edge 258.
- Throughput: 1 pixel/cycle when unstalled, no bubbles between pixels.
- out_x/out_y/out_color hold while out_valid & !out_ready (AXI-style stability). out_valid never drops without xfer.

Decomposition:
- Package t06_scan_pkg:
  - state enum {IDLE, SCAN, DRAIN, DONE}.
  - Default colour constants.
  - Pixel-class enum {BG, APPLE, BODY, HEAD}.
- Sub-module t06_coord_counter: x/y raster counter with enable, clear and last flag.
- The FSM, classifier and output register stay in the top level.

Test Plan:
- Reset, then start with out_ready=1, body/head/apple=0 -> 256 pixels, all COLOR_BG, in raster order (0,0),(1,0)..(15,15); frame_done exactly one cycle, after edge 257.
- Bench models head at (5,3), body at (4,3),(3,3), apple at (10,12) -> pixel (5,3)=16'hFFE0, (4,3)=(3,3)=16'h07E0, (10,12)=16'hF800, others 16'h0000.
- Head and apple both high at (7,7), game_over=1 -> (7,7)=16'hF81F; body cells also 16'hF81F.
- out_ready low for 5 cycles while pixel (2,0) is presented -> out_x=2, out_y=0, out_color stable; x/y stable; no pixel lost or duplicated; total accepted = 256.
- start pulsed at pixel 100 and in the DONE cycle -> ignored; exactly one frame, one frame_done.
- reset asserted at pixel 130 -> outputs zero immediately, no frame_done; a new start gives a complete 256-pixel frame from (0,0).
